// File: rtl/ddr_ring_sched.sv
// ddr_ring_sched: address and space scheduler for the DDR packet ring.
// Grants write bursts that never cross a 4KB page or the ring end.
// A burst's bytes become readable only once its B response arrives.
// Single-beat read addresses are issued over the committed bytes.
// Ring space is handed back as read beats are consumed downstream.
module ddr_ring_sched #(
    parameter int              ADDR_WIDTH      = 31,
    parameter int              DATA_WIDTH      = 512,
    parameter longint unsigned RING_BASE       = 0,
    parameter longint unsigned RING_BYTES      = 64'd1 << 30,
    parameter int              MAX_OUTSTANDING = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_req_valid,
    input  logic [6:0]                         wr_req_beats,
    output logic                               wr_req_ready,
    output logic [ADDR_WIDTH-1:0]              wr_grant_addr,
    output logic [6:0]                         wr_grant_beats,
    input  logic                               m_axi_bvalid,
    input  logic [1:0]                         m_axi_bresp,
    output logic                               m_axi_bready,
    input  logic                               rd_en,
    output logic                               rd_req_valid,
    input  logic                               rd_req_ready,
    output logic [ADDR_WIDTH-1:0]              rd_req_addr,
    input  logic                               rd_done,
    output logic [ADDR_WIDTH:0]                used_bytes,
    output logic [ADDR_WIDTH:0]                avail_bytes,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic [15:0]                        bresp_err_cnt
);

    localparam int CW         = ADDR_WIDTH + 1;
    localparam int OW         = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW         = $clog2(MAX_OUTSTANDING);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    localparam logic [CW-1:0] RING_SIZE = CW'(RING_BYTES);
    localparam logic [CW-1:0] RING_END  = CW'(RING_BASE + RING_BYTES);
    localparam logic [CW-1:0] BEAT_SIZE = CW'(BEAT_BYTES);
    localparam logic [CW-1:0] PAGE_SIZE = CW'(4096);
    localparam logic [OW-1:0] OUT_LIMIT = OW'(MAX_OUTSTANDING);

    // Ring pointers and accounting state
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH-1:0] commit_ptr_reg;
    logic [CW-1:0]         used_reg;
    logic [CW-1:0]         avail_reg;
    logic [OW-1:0]         out_reg;
    logic [15:0]           err_reg;
    // Low during reset and for the first clock after it, so no grant is
    // offered while the block is held in reset.
    logic                  active_reg;

    // Length FIFO: one entry per granted burst still waiting for its B.
    // Occupancy always equals out_reg, so no separate count is kept.
    logic [6:0]            len_mem [MAX_OUTSTANDING];
    logic [PW-1:0]         fifo_wr_idx_reg;
    logic [PW-1:0]         fifo_rd_idx_reg;

    // Combinational next-state terms
    logic [CW-1:0] wr_ptr_ext;
    logic [CW-1:0] req_bytes;
    logic [CW-1:0] page_bytes;
    logic [CW-1:0] end_bytes;
    logic [CW-1:0] grant_bytes;
    logic [CW-1:0] free_bytes;
    logic [CW-1:0] commit_bytes;
    logic [6:0]    head_beats;
    logic          grant_fire;
    logic          b_commit;
    logic          b_err;
    logic          rd_fire;
    logic          done_ok;
    logic [CW-1:0] used_next;
    logic [CW-1:0] avail_next;
    logic [OW-1:0] out_next;

    // Advance a ring pointer, folding back to the base on reaching the end
    function automatic logic [ADDR_WIDTH-1:0] ring_advance(
        input logic [ADDR_WIDTH-1:0] ptr,
        input logic [CW-1:0]         bytes
    );
        logic [CW-1:0] sum;
        sum = {1'b0, ptr} + bytes;
        if (sum >= RING_END) begin
            sum = sum - RING_SIZE;
        end
        return ADDR_WIDTH'(sum);
    endfunction

    // Grant length: request clipped to the 4KB page and to the ring end
    always_comb begin
        wr_ptr_ext  = {1'b0, wr_ptr_reg};
        req_bytes   = CW'(wr_req_beats) << BEAT_SHIFT;
        page_bytes  = PAGE_SIZE - (wr_ptr_ext & (PAGE_SIZE - CW'(1)));
        end_bytes   = RING_END - wr_ptr_ext;
        grant_bytes = req_bytes;
        if (page_bytes < grant_bytes) begin
            grant_bytes = page_bytes;
        end
        if (end_bytes < grant_bytes) begin
            grant_bytes = end_bytes;
        end
    end

    assign free_bytes     = RING_SIZE - used_reg;
    assign wr_grant_beats = 7'(grant_bytes >> BEAT_SHIFT);
    assign wr_grant_addr  = wr_ptr_reg;
    // Gating looks only at registered counters: space or credit released
    // in this same cycle is offered from the next cycle on.
    assign wr_req_ready   = active_reg && wr_req_valid &&
                            (out_reg < OUT_LIMIT) && (grant_bytes <= free_bytes);
    assign grant_fire     = wr_req_valid && wr_req_ready;

    // Responses come back in order, so the head length belongs to this B.
    // A B with nothing outstanding has no burst behind it: count, don't commit.
    assign head_beats   = len_mem[fifo_rd_idx_reg];
    assign commit_bytes = CW'(head_beats) << BEAT_SHIFT;
    assign b_commit     = m_axi_bvalid && (out_reg != '0);
    assign b_err        = m_axi_bvalid && ((out_reg == '0) || (m_axi_bresp != 2'b00));
    assign m_axi_bready = 1'b1;

    assign rd_req_valid = rd_en && (avail_reg != '0);
    assign rd_req_addr  = rd_ptr_reg;
    assign rd_fire      = rd_req_valid && rd_req_ready;
    // With used == avail nothing has been read out, so there is no beat
    // a done could refer to.
    assign done_ok      = rd_done && (used_reg != avail_reg);

    // Net per-cycle updates when several events land together
    always_comb begin
        used_next  = used_reg + (grant_fire ? grant_bytes : '0)
                              - (done_ok ? BEAT_SIZE : '0);
        avail_next = avail_reg + (b_commit ? commit_bytes : '0)
                               - (rd_fire ? BEAT_SIZE : '0);
        out_next   = out_reg + OW'(grant_fire) - OW'(b_commit);
    end

    // Ring pointers and FIFO indices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg      <= ADDR_WIDTH'(RING_BASE);
            rd_ptr_reg      <= ADDR_WIDTH'(RING_BASE);
            commit_ptr_reg  <= ADDR_WIDTH'(RING_BASE);
            fifo_wr_idx_reg <= '0;
            fifo_rd_idx_reg <= '0;
        end else begin
            if (grant_fire) begin
                wr_ptr_reg      <= ring_advance(wr_ptr_reg, grant_bytes);
                fifo_wr_idx_reg <= fifo_wr_idx_reg + PW'(1);
            end
            if (b_commit) begin
                commit_ptr_reg  <= ring_advance(commit_ptr_reg, commit_bytes);
                fifo_rd_idx_reg <= fifo_rd_idx_reg + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr_reg <= ring_advance(rd_ptr_reg, BEAT_SIZE);
            end
        end
    end

    // Byte/credit counters, saturating error count and grant enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_reg   <= '0;
            avail_reg  <= '0;
            out_reg    <= '0;
            err_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            used_reg   <= used_next;
            avail_reg  <= avail_next;
            out_reg    <= out_next;
            active_reg <= 1'b1;
            if (b_err && (err_reg != 16'hFFFF)) begin
                err_reg <= err_reg + 16'd1;
            end
        end
    end

    // Length storage; emptiness is tracked by the indices alone
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            len_mem[fifo_wr_idx_reg] <= wr_grant_beats;
        end
    end

    assign used_bytes    = used_reg;
    assign avail_bytes   = avail_reg;
    assign outstanding   = out_reg;
    assign bresp_err_cnt = err_reg;

endmodule

// File: tb/tb_ddr_ring_sched.sv
// Testbench for ddr_ring_sched with an 8KB ring so full/wrap cases are reachable.
module tb_ddr_ring_sched;

    localparam int AW = 31;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req_valid = 1'b0;
    logic [6:0]    wr_req_beats = '0;
    logic          wr_req_ready;
    logic [AW-1:0] wr_grant_addr;
    logic [6:0]    wr_grant_beats;
    logic          m_axi_bvalid = 1'b0;
    logic [1:0]    m_axi_bresp = '0;
    logic          m_axi_bready;
    logic          rd_en = 1'b0;
    logic          rd_req_valid;
    logic          rd_req_ready = 1'b0;
    logic [AW-1:0] rd_req_addr;
    logic          rd_done = 1'b0;
    logic [AW:0]   used_bytes;
    logic [AW:0]   avail_bytes;
    logic [4:0]    outstanding;
    logic [15:0]   bresp_err_cnt;

    always #5 clk = ~clk;

    ddr_ring_sched #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(512),
        .RING_BASE(0),
        .RING_BYTES(8192),
        .MAX_OUTSTANDING(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_req_valid(wr_req_valid),
        .wr_req_beats(wr_req_beats),
        .wr_req_ready(wr_req_ready),
        .wr_grant_addr(wr_grant_addr),
        .wr_grant_beats(wr_grant_beats),
        .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bresp(m_axi_bresp),
        .m_axi_bready(m_axi_bready),
        .rd_en(rd_en),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr),
        .rd_done(rd_done),
        .used_bytes(used_bytes),
        .avail_bytes(avail_bytes),
        .outstanding(outstanding),
        .bresp_err_cnt(bresp_err_cnt)
    );

    typedef struct {
        int wv, wb, bv, br, re, rr, dn;
        int e_ready, e_gaddr, e_gbeats, e_rvalid, e_used, e_avail, e_out, e_err;
    } vec_t;

    vec_t          tbl [13];
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] addr_q [$];
    int            len_q [$];
    longint        exp_avail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge
    task automatic drive(input int wv, input int wb, input int bv, input int br,
                         input int re, input int rr, input int dn);
        @(posedge clk);
        #1;
        wr_req_valid = (wv != 0);
        wr_req_beats = 7'(wb);
        m_axi_bvalid = (bv != 0);
        m_axi_bresp  = 2'(br);
        rd_en        = (re != 0);
        rd_req_ready = (rr != 0);
        rd_done      = (dn != 0);
        @(negedge clk);
    endtask

    task automatic push_grant(input logic [63:0] addr, input int beats);
        for (int i = 0; i < beats; i++) begin
            addr_q.push_back(AW'(addr + 64'(i * 64)));
        end
        len_q.push_back(beats);
        $display("grant addr=0x%0h beats=%0d", addr, beats);
    endtask

    task automatic grant_chk(input string name, input logic [63:0] addr, input int beats);
        chk({name, " ready"}, 64'(wr_req_ready), 64'd1);
        chk({name, " addr"}, 64'(wr_grant_addr), addr);
        chk({name, " beats"}, 64'(wr_grant_beats), 64'(beats));
        push_grant(addr, beats);
    endtask

    task automatic b_pop();
        if (len_q.size() != 0) begin
            int l;
            l = len_q.pop_front();
            exp_avail += longint'(l) * 64;
            $display("b response commits beats=%0d", l);
        end
    endtask

    task automatic read_pop(input string name);
        if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: read accepted with nothing expected, addr 0x%0h", name, rd_req_addr);
        end else begin
            logic [AW-1:0] e;
            e = addr_q.pop_front();
            chk(name, 64'(rd_req_addr), 64'(e));
            exp_avail -= 64;
            $display("read addr=0x%0h", e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //            wv wb bv br re rr dn | rdy gaddr    gb rv used  avail out err
        tbl[0]  = '{1, 24, 0, 0, 0, 0, 0,   1, 'h0,    24, 0, 0,    0,    0, 0};
        tbl[1]  = '{0, 0,  0, 0, 1, 0, 0,   0, 'h600,  0,  0, 1536, 0,    1, 0};
        tbl[2]  = '{0, 0,  1, 0, 1, 0, 0,   0, 'h600,  0,  0, 1536, 0,    1, 0};
        tbl[3]  = '{1, 39, 0, 0, 1, 0, 0,   1, 'h600,  39, 1, 1536, 1536, 0, 0};
        tbl[4]  = '{1, 10, 0, 0, 1, 0, 0,   1, 'hFC0,  1,  1, 4032, 1536, 1, 0};
        tbl[5]  = '{1, 9,  0, 0, 1, 0, 0,   1, 'h1000, 9,  1, 4096, 1536, 2, 0};
        tbl[6]  = '{1, 53, 0, 0, 1, 0, 0,   1, 'h1240, 53, 1, 4672, 1536, 3, 0};
        tbl[7]  = '{1, 4,  0, 0, 1, 0, 0,   1, 'h1F80, 2,  1, 8064, 1536, 4, 0};
        tbl[8]  = '{1, 1,  0, 0, 1, 0, 0,   0, 'h0,    1,  1, 8192, 1536, 5, 0};
        tbl[9]  = '{1, 1,  0, 0, 1, 1, 0,   0, 'h0,    1,  1, 8192, 1536, 5, 0};
        tbl[10] = '{1, 1,  0, 0, 1, 0, 1,   0, 'h0,    1,  1, 8192, 1472, 5, 0};
        tbl[11] = '{1, 1,  0, 0, 1, 0, 0,   1, 'h0,    1,  1, 8128, 1472, 5, 0};
        tbl[12] = '{0, 0,  0, 0, 0, 0, 0,   0, 'h40,   0,  0, 8192, 1472, 6, 0};

        // Reset with a request pending: nothing may be granted
        wr_req_valid = 1'b1;
        wr_req_beats = 7'd24;
        rd_en        = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst ready", 64'(wr_req_ready), 64'd0);
        chk("rst gaddr", 64'(wr_grant_addr), 64'd0);
        chk("rst used", 64'(used_bytes), 64'd0);
        chk("rst avail", 64'(avail_bytes), 64'd0);
        chk("rst out", 64'(outstanding), 64'd0);
        chk("rst rvalid", 64'(rd_req_valid), 64'd0);
        chk("rst err", 64'(bresp_err_cnt), 64'd0);
        chk("bready", 64'(m_axi_bready), 64'd1);
        wr_req_valid = 1'b0;
        rd_en        = 1'b0;
        rst_n        = 1'b1;

        // Grants, page split, ring wrap, ring full, same-cycle done vs grant
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].wv, tbl[i].wb, tbl[i].bv, tbl[i].br, tbl[i].re, tbl[i].rr, tbl[i].dn);
            chk($sformatf("v%0d ready", i), 64'(wr_req_ready), 64'(tbl[i].e_ready));
            chk($sformatf("v%0d gaddr", i), 64'(wr_grant_addr), 64'(tbl[i].e_gaddr));
            chk($sformatf("v%0d gbeats", i), 64'(wr_grant_beats), 64'(tbl[i].e_gbeats));
            chk($sformatf("v%0d rvalid", i), 64'(rd_req_valid), 64'(tbl[i].e_rvalid));
            chk($sformatf("v%0d used", i), 64'(used_bytes), 64'(tbl[i].e_used));
            chk($sformatf("v%0d avail", i), 64'(avail_bytes), 64'(tbl[i].e_avail));
            chk($sformatf("v%0d out", i), 64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("v%0d err", i), 64'(bresp_err_cnt), 64'(tbl[i].e_err));
            if (tbl[i].e_ready != 0) push_grant(64'(tbl[i].e_gaddr), tbl[i].e_gbeats);
            if (tbl[i].bv != 0) b_pop();
            if (tbl[i].re != 0 && tbl[i].rr != 0 && tbl[i].e_rvalid != 0)
                read_pop($sformatf("v%0d raddr", i));
        end

        // Asynchronous reset in the middle of traffic
        @(posedge clk);
        #1;
        wr_req_valid = 1'b1;
        wr_req_beats = 7'd5;
        rd_en        = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted");
        chk("arst ready", 64'(wr_req_ready), 64'd0);
        chk("arst gaddr", 64'(wr_grant_addr), 64'd0);
        chk("arst used", 64'(used_bytes), 64'd0);
        chk("arst avail", 64'(avail_bytes), 64'd0);
        chk("arst out", 64'(outstanding), 64'd0);
        chk("arst rvalid", 64'(rd_req_valid), 64'd0);
        chk("arst raddr", 64'(rd_req_addr), 64'd0);
        wr_req_valid = 1'b0;
        rd_en        = 1'b0;
        addr_q.delete();
        len_q.delete();
        exp_avail = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Error response still commits; then three single-beat reads
        drive(1, 3, 0, 0, 0, 0, 0);
        grant_chk("b3", 64'h0, 3);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("b3 rvalid pre", 64'(rd_req_valid), 64'd0);
        chk("b3 used", 64'(used_bytes), 64'd192);
        drive(0, 0, 1, 2, 1, 0, 0);
        chk("b3 avail pre", 64'(avail_bytes), 64'd0);
        b_pop();
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("b3 avail", 64'(avail_bytes), 64'd192);
        chk("b3 avail sb", 64'(avail_bytes), 64'(exp_avail));
        chk("b3 err", 64'(bresp_err_cnt), 64'd1);
        chk("b3 out", 64'(outstanding), 64'd0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 1, 0);
            chk($sformatf("rd%0d rvalid", k), 64'(rd_req_valid), 64'd1);
            read_pop($sformatf("rd%0d addr", k));
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("empty rvalid", 64'(rd_req_valid), 64'd0);
        chk("empty avail", 64'(avail_bytes), 64'(exp_avail));

        // B with nothing outstanding: error count only
        drive(0, 0, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("orphan err", 64'(bresp_err_cnt), 64'd2);
        chk("orphan out", 64'(outstanding), 64'd0);
        chk("orphan avail", 64'(avail_bytes), 64'd0);

        // Three dones release the burst; a fourth is ignored
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            $display("rd_done %0d", k);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("done used", 64'(used_bytes), 64'd0);

        // Outstanding limit: 16 grants, 17th blocked, B frees it a cycle later
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            grant_chk($sformatf("os%0d", i), 64'h0C0 + 64'(i * 64), 1);
        end
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("os17 ready", 64'(wr_req_ready), 64'd0);
        chk("os17 out", 64'(outstanding), 64'd16);
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("osB ready", 64'(wr_req_ready), 64'd0);
        b_pop();
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("osR out", 64'(outstanding), 64'd15);
        grant_chk("osR", 64'h4C0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("osF out", 64'(outstanding), 64'd16);
        chk("osF used", 64'(used_bytes), 64'd1088);
        chk("osF avail", 64'(avail_bytes), 64'(exp_avail));
        chk("osF err", 64'(bresp_err_cnt), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
